// File: rtl/ternary_r_feeder_pkg.sv
// Shared constants for the ternary r-coefficient feeder: canonical 2-bit trit codes
// and the elaboration-time helpers used to size counters and word geometry.
package ternary_r_feeder_pkg;

    localparam logic [1:0] T_ZERO = 2'b00;
    localparam logic [1:0] T_POS  = 2'b01;
    localparam logic [1:0] T_NEG  = 2'b11;
    localparam logic [1:0] T_BAD  = 2'b10;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int cdiv(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int codes_per_word(input int width);
        return width / 2;
    endfunction

endpackage

// File: rtl/ternary_r_feeder_trit_unpack.sv
// Selects one 2-bit trit from the active word and folds the unused 10 code to zero,
// flagging it so the feeder can record the corruption.
module ternary_r_feeder_trit_unpack
    import ternary_r_feeder_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]                           word,
    input  logic [clog2(codes_per_word(W))-1:0]    slot,
    output logic [1:0]                             code,
    output logic                                   err
);

    logic [1:0] raw;

    assign raw = word[{slot, 1'b0} +: 2];

    always_comb begin
        code = T_ZERO;
        err  = 1'b0;
        case (raw)
            T_POS:   code = T_POS;
            T_NEG:   code = T_NEG;
            T_BAD:   err  = 1'b1;
            default: code = T_ZERO;
        endcase
    end

endmodule

// File: rtl/ternary_r_feeder.sv
// Unpacks the AXI4-Stream packed ternary polynomial r and streams one canonical
// 2-bit code per cycle to the multiplier core, with a one-word prefetch buffer.
module ternary_r_feeder
    import ternary_r_feeder_pkg::*;
#(
    parameter int N = 509,
    parameter int P = 3,
    parameter int W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [W-1:0]              s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    output logic [1:0]                r_out,
    output logic                      r_valid,
    input  logic                      r_ready,
    output logic                      r_last,
    output logic [clog2(N-1)-1:0]     r_idx,
    output logic                      busy,
    output logic                      done,
    output logic                      code_err,
    output logic                      tlast_err
);

    localparam int CPW = codes_per_word(W);
    localparam int WPP = cdiv(N, CPW);
    localparam int SW  = clog2(CPW);
    localparam int WCW = clog2(WPP + 1);
    localparam int IW  = clog2(N - 1);

    localparam logic [WCW-1:0] WPP_C    = WCW'(WPP);
    localparam logic [WCW-1:0] WLAST_C  = WCW'(WPP - 1);
    localparam logic [IW-1:0]  LAST_C   = IW'(N - 1);
    localparam logic [SW-1:0]  SLOT_END = SW'(CPW - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    if (P != 3) begin : g_p_check
        $error("ternary_r_feeder: only p=3 (2-bit ternary codes) is supported");
    end

    logic [1:0]     state;
    logic [W-1:0]   sr;
    logic [W-1:0]   pf;
    logic           pf_full;
    logic [SW-1:0]  slot;
    logic [WCW-1:0] wcnt;
    logic [IW-1:0]  ccnt;

    logic [1:0] code;
    logic       bad;
    logic       emit;
    logic       words_left;
    logic       ax_hs;
    logic       r_hs;
    logic       last_c;
    logic       slot_end;
    logic       tlast_bad;
    logic       direct_reload;

    ternary_r_feeder_trit_unpack #(.W(W)) u_unpack (
        .word (sr),
        .slot (slot),
        .code (code),
        .err  (bad)
    );

    assign emit          = (state == S_EMIT);
    assign words_left    = (wcnt < WPP_C);
    assign s_axis_tready = ((state == S_LOAD) && words_left) || (emit && !pf_full && words_left);
    assign ax_hs         = s_axis_tvalid && s_axis_tready;
    assign r_hs          = emit && r_ready;
    assign last_c        = (ccnt == LAST_C);
    assign slot_end      = (slot == SLOT_END);
    assign tlast_bad     = s_axis_tlast ? (wcnt < WLAST_C) : (wcnt == WLAST_C);

    // A word arriving exactly as the active word drains with PF empty goes straight
    // into SR, so the stream keeps running instead of falling back to LOAD.
    assign direct_reload = r_hs && !last_c && slot_end && !pf_full && ax_hs;

    assign r_valid = emit;
    assign r_out   = emit ? code : T_ZERO;
    assign r_last  = emit && last_c;
    assign r_idx   = ccnt;
    assign busy    = (state == S_LOAD) || emit;
    assign done    = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sr        <= '0;
            pf        <= '0;
            pf_full   <= 1'b0;
            slot      <= '0;
            wcnt      <= '0;
            ccnt      <= '0;
            code_err  <= 1'b0;
            tlast_err <= 1'b0;
        end else begin
            if (ax_hs) begin
                wcnt <= wcnt + 1'b1;
                if (tlast_bad) tlast_err <= 1'b1;
            end
            if (emit && bad) code_err <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        ccnt      <= '0;
                        wcnt      <= '0;
                        slot      <= '0;
                        pf_full   <= 1'b0;
                        code_err  <= 1'b0;
                        tlast_err <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (ax_hs) begin
                        sr    <= s_axis_tdata;
                        slot  <= '0;
                        state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (r_hs) begin
                        if (last_c) begin
                            state <= S_DONE;
                        end else begin
                            ccnt <= ccnt + 1'b1;
                            if (slot_end) begin
                                slot <= '0;
                                if (pf_full) begin
                                    sr      <= pf;
                                    pf_full <= 1'b0;
                                end else if (ax_hs) begin
                                    sr <= s_axis_tdata;
                                end else begin
                                    state <= S_LOAD;
                                end
                            end else begin
                                slot <= slot + 1'b1;
                            end
                        end
                    end
                    if (ax_hs && !direct_reload) begin
                        pf      <= s_axis_tdata;
                        pf_full <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ternary_r_feeder.sv
// Scoreboard bench for ternary_r_feeder: accepted words expand into expected
// coefficients in a queue; a negedge monitor pops and compares each r handshake.
module tb_ternary_r_feeder;

    localparam int N   = 509;
    localparam int W   = 32;
    localparam int CPW = 16;
    localparam int WPP = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [1:0]    r_out;
    logic          r_valid;
    logic          r_ready = 1'b0;
    logic          r_last;
    logic [8:0]    r_idx;
    logic          busy;
    logic          done;
    logic          code_err;
    logic          tlast_err;

    always #5 clk = ~clk;

    ternary_r_feeder #(.N(N), .P(3), .W(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .r_out         (r_out),
        .r_valid       (r_valid),
        .r_ready       (r_ready),
        .r_last        (r_last),
        .r_idx         (r_idx),
        .busy          (busy),
        .done          (done),
        .code_err      (code_err),
        .tlast_err     (tlast_err)
    );

    typedef struct {
        logic [1:0] code;
        int         idx;
        logic       last;
    } exp_t;

    exp_t        q[$];
    int          vecs = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] words[WPP];
    logic        tlast_f[WPP];
    bit          stop = 1'b0;
    int          pops = 0;
    int          done_cnt = 0;
    bit          expect_done = 1'b0;
    bit          hold_pending = 1'b0;
    logic [1:0]  hold_code;
    logic [8:0]  hold_idx;
    int          first_cyc = -1;
    int          last_cyc = -1;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected stream: trit k of accepted word w is coefficient w*16+k, kept only below N.
    function automatic void push_word(input int wi);
        exp_t       e;
        logic [1:0] raw;
        logic [31:0] wd;
        wd = words[wi];
        for (int k = 0; k < CPW; k++) begin
            if (wi * CPW + k < N) begin
                raw    = wd[2*k +: 2];
                e.code = (raw == 2'b10) ? 2'b00 : raw;
                e.idx  = wi * CPW + k;
                e.last = (e.idx == N - 1);
                q.push_back(e);
            end
        end
    endfunction

    function automatic logic [31:0] legal_word();
        logic [31:0] wd;
        int t;
        wd = '0;
        for (int k = 0; k < CPW; k++) begin
            t = $urandom_range(0, 2);
            wd[2*k +: 2] = (t == 0) ? 2'b00 : ((t == 1) ? 2'b01 : 2'b11);
        end
        return wd;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (done) done_cnt++;
            if (expect_done) begin
                check("done_pulse", done, 1);
                expect_done = 1'b0;
            end
            if (hold_pending) begin
                check("hold_stable", {r_valid, r_out, r_idx}, {1'b1, hold_code, hold_idx});
                hold_pending = 1'b0;
            end
            if (r_valid && r_ready) begin
                if (q.size() == 0) begin
                    vecs++;
                    fails++;
                    $display("FAIL unexpected_coef: got idx %0d code %0b, expected none", r_idx, r_out);
                end else begin
                    e = q.pop_front();
                    check("coef", {r_out, r_idx, r_last}, {e.code, 9'(e.idx), e.last});
                    if (e.idx == 0) first_cyc = cyc;
                    if (e.last) begin
                        last_cyc    = cyc;
                        expect_done = 1'b1;
                    end
                    pops++;
                end
            end else if (r_valid) begin
                hold_pending = 1'b1;
                hold_code    = r_out;
                hold_idx     = r_idx;
            end
        end
    end

    task automatic feed(input int tvmode);
        bit hs;
        for (int wi = 0; wi < WPP && !stop; wi++) begin
            s_axis_tdata = words[wi];
            s_axis_tlast = tlast_f[wi];
            hs = 1'b0;
            while (!hs && !stop) begin
                s_axis_tvalid = (tvmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                @(negedge clk);
                hs = s_axis_tvalid && s_axis_tready && rst_n;
                if (hs) push_word(wi);
                @(posedge clk);
                #1;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic ready_gen(input int rmode);
        int ph;
        ph = 0;
        while (!stop) begin
            case (rmode)
                0:       r_ready = 1'b1;
                1:       r_ready = (ph % 2 == 0);
                default: r_ready = 1'($urandom_range(0, 1));
            endcase
            ph++;
            @(posedge clk);
            #1;
        end
        r_ready = 1'b0;
    endtask

    task automatic run_poly(input int rmode, input int tvmode, input int abort_at);
        bit exp_ce;
        bit exp_te;
        int t;
        exp_ce = 1'b0;
        for (int w = 0; w < WPP; w++)
            for (int k = 0; k < CPW; k++)
                if (w * CPW + k < N && words[w][2*k +: 2] == 2'b10) exp_ce = 1'b1;
        exp_te = !tlast_f[WPP-1];
        for (int w = 0; w < WPP - 1; w++)
            if (tlast_f[w]) exp_te = 1'b1;

        pops = 0; done_cnt = 0; stop = 1'b0; first_cyc = -1; last_cyc = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        fork
            feed(tvmode);
            ready_gen(rmode);
        join_none
        @(negedge clk);
        check("busy_after_start", busy, 1);
        check("errs_cleared", {code_err, tlast_err}, 0);

        t = 0;
        while (done_cnt == 0 && t < 8000 && !(abort_at > 0 && pops >= abort_at)) begin
            @(posedge clk);
            t++;
        end

        if (abort_at > 0) begin
            check("abort_reached", pops >= abort_at, 1);
            #1 rst_n = 1'b0;
            stop = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            q.delete();
            hold_pending  = 1'b0;
            expect_done   = 1'b0;
            s_axis_tvalid = 1'b0;
            r_ready       = 1'b0;
            rst_n         = 1'b1;
            repeat (4) @(negedge clk);
            check("no_done_after_abort", done_cnt, 0);
            check("idle_after_abort", {busy, r_valid, s_axis_tready, r_idx}, 0);
        end else begin
            check("done_seen", done_cnt > 0, 1);
            stop = 1'b1;
            repeat (3) @(negedge clk);
            check("done_count", done_cnt, 1);
            check("coef_count", pops, N);
            check("queue_empty", q.size(), 0);
            check("busy_clear", busy, 0);
            check("code_err", code_err, exp_ce);
            check("tlast_err", tlast_err, exp_te);
        end
    endtask

    initial begin
        // Reset and idle behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("outputs_in_reset", {s_axis_tready, r_out, r_valid, r_last, r_idx, busy, done, code_err, tlast_err}, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("outputs_after_reset", {s_axis_tready, r_out, r_valid, r_last, r_idx, busy, done, code_err, tlast_err}, 0);
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("tready_idle", s_axis_tready, 0);
        end
        s_axis_tvalid = 1'b0;

        // All +1, full throughput
        for (int w = 0; w < WPP; w++) begin
            words[w]   = 32'h5555_5555;
            tlast_f[w] = (w == WPP - 1);
        end
        run_poly(0, 0, -1);
        check("no_gaps", last_cyc - first_cyc, N - 1);

        // Backpressure with alternating ready
        for (int w = 0; w < WPP; w++) words[w] = 32'hFFFF_FFFC;
        run_poly(1, 0, -1);

        // Illegal code in word 0, random handshakes
        for (int w = 0; w < WPP; w++) words[w] = legal_word();
        words[0] = 32'h0000_0002;
        run_poly(2, 1, -1);

        // Early tlast on word 10; stream still completes
        for (int w = 0; w < WPP; w++) words[w] = legal_word();
        tlast_f[10] = 1'b1;
        run_poly(2, 1, -1);
        tlast_f[10] = 1'b0;

        // Missing tlast on the final word
        for (int w = 0; w < WPP; w++) words[w] = legal_word();
        tlast_f[WPP-1] = 1'b0;
        run_poly(0, 1, -1);
        tlast_f[WPP-1] = 1'b1;

        // Illegal codes only in discarded upper slots of the final word
        for (int w = 0; w < WPP; w++) words[w] = legal_word();
        words[WPP-1][31:26] = 6'b101010;
        run_poly(2, 0, -1);

        // Abort mid-stream, then a fresh polynomial
        for (int w = 0; w < WPP; w++) words[w] = legal_word();
        run_poly(0, 0, 200);
        for (int w = 0; w < WPP; w++) words[w] = legal_word();
        run_poly(2, 1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
